// File: rtl/bitfusion_pkg.sv
// Shared types and constants for the bitfusion psum datapath.
package bitfusion_pkg;

  localparam int PSUM_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } psum_acc_state_t;

endpackage

// File: rtl/psum_accumulator_if.sv
// Handshake/data bundle between a fusion-unit column, the accumulator and the
// output buffer. The slave modport is the accumulator side.
interface psum_accumulator_if
  import bitfusion_pkg::*;
#(
  parameter int PSUM_W = bitfusion_pkg::PSUM_W,
  parameter int ACC_W  = 48,
  parameter int LEN_W  = 16
) ();

  logic              start;
  logic [LEN_W-1:0]  acc_len;
  logic [PSUM_W-1:0] psum_in;
  logic              psum_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              out_valid;
  logic              ovf;
  logic              busy;

  modport master (
    output start, acc_len, psum_in, psum_valid, out_ready,
    input  acc_out, out_valid, ovf, busy
  );

  modport slave (
    input  start, acc_len, psum_in, psum_valid, out_ready,
    output acc_out, out_valid, ovf, busy
  );

endinterface

// File: rtl/psum_accumulator_adder.sv
// Combinational W-bit two's complement add with signed-overflow flag.
module psum_acc_adder #(
  parameter int W = 48
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_ovf
);

  // Wrap-around sum; overflow when operands agree in sign and the sum does not.
  always_comb begin
    o_sum = i_a + i_b;
    o_ovf = (i_a[W-1] == i_b[W-1]) && (o_sum[W-1] != i_a[W-1]);
  end

endmodule

// File: rtl/psum_accumulator.sv
// Per-column psum accumulator: sums acc_len signed psum beats into one
// activation, holds it under valid/ready and flags signed overflow.
// Optional feature macro: PSUM_ACC_RELU_EN (clamp negative results to 0).
module psum_accumulator
  import bitfusion_pkg::*;
#(
  parameter int PSUM_W = bitfusion_pkg::PSUM_W,
  parameter int ACC_W  = 48,  // must be >= PSUM_W
  parameter int LEN_W  = 16
) (
  input  logic                 clk,
  input  logic                 RST,
  psum_accumulator_if.slave    bus
);

  psum_acc_state_t   r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  r_len;
  logic [ACC_W-1:0]  r_acc_out;
  logic              r_out_valid;
  logic              r_ovf;

  logic [ACC_W-1:0]  w_psum_ext;
  logic [ACC_W-1:0]  w_sum;
  logic              w_add_ovf;
  logic [ACC_W-1:0]  w_result;
  logic              w_start_ok;
  logic              w_last;

  assign w_psum_ext = ACC_W'($signed(bus.psum_in));
  assign w_start_ok = bus.start && (bus.acc_len != '0);
  assign w_last     = (r_cnt == r_len - 1'b1);

  psum_acc_adder #(.W(ACC_W)) u_add (
    .i_a   (r_acc),
    .i_b   (w_psum_ext),
    .o_sum (w_sum),
    .o_ovf (w_add_ovf)
  );

  // Result presented on entry to HOLD.
`ifdef PSUM_ACC_RELU_EN
  assign w_result = w_sum[ACC_W-1] ? '0 : w_sum;
`else
  assign w_result = w_sum;
`endif

  // FSM, beat counter, accumulator and output registers.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_acc_out   <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_len   <= bus.acc_len;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_state <= ACCUM;
          end
        end
        ACCUM: begin
          if (bus.psum_valid) begin
            r_ovf <= r_ovf | w_add_ovf;
            if (w_last) begin
              r_acc_out   <= w_result;
              r_out_valid <= 1'b1;
              r_state     <= HOLD;
            end else begin
              r_acc <= w_sum;
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          // Beats arriving here are dropped; the result stays frozen.
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (w_start_ok) begin
              r_len   <= bus.acc_len;
              r_acc   <= '0;
              r_cnt   <= '0;
              r_ovf   <= 1'b0;
              r_state <= ACCUM;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.acc_out   = r_acc_out;
  assign bus.out_valid = r_out_valid;
  assign bus.ovf       = r_ovf;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench: drives one stimulus stream into a 48-bit and a 32-bit accumulator and
// checks both against an arithmetic reference model.
module tb_psum_accumulator;
  import bitfusion_pkg::*;

`ifdef PSUM_ACC_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [15:0] acc_len = '0;
  logic [31:0] psum_in = '0;
  logic        psum_valid = 1'b0;
  logic        out_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  psum_accumulator_if #(.PSUM_W(32), .ACC_W(48), .LEN_W(16)) b48 ();
  psum_accumulator_if #(.PSUM_W(32), .ACC_W(32), .LEN_W(16)) b32 ();

  assign b48.start = start;      assign b32.start = start;
  assign b48.acc_len = acc_len;  assign b32.acc_len = acc_len;
  assign b48.psum_in = psum_in;  assign b32.psum_in = psum_in;
  assign b48.psum_valid = psum_valid; assign b32.psum_valid = psum_valid;
  assign b48.out_ready = out_ready;   assign b32.out_ready = out_ready;

  psum_accumulator #(.PSUM_W(32), .ACC_W(48), .LEN_W(16)) dut48 (.clk(clk), .RST(rst), .bus(b48));
  psum_accumulator #(.PSUM_W(32), .ACC_W(32), .LEN_W(16)) dut32 (.clk(clk), .RST(rst), .bus(b32));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Exact-integer reference: a step overflows when the true sum is not
  // representable in w bits; the kept value is the w-bit wrap of it.
  function automatic void model(input logic [31:0] beats[$], input int w,
                                output logic [63:0] res, output bit ovf);
    longint acc, exact, wrapped, x;
    acc = 0; ovf = 1'b0;
    foreach (beats[i]) begin
      x = longint'($signed(beats[i]));
      exact = acc + x;
      wrapped = (exact <<< (64 - w)) >>> (64 - w);
      if (wrapped != exact) ovf = 1'b1;
      acc = wrapped;
    end
    if (RELU && acc < 0) acc = 0;
    res = acc;
  endfunction

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    checks++;
    if ({b48.acc_out, b48.out_valid, b48.ovf, b48.busy} !== 51'd0 ||
        {b32.acc_out, b32.out_valid, b32.ovf, b32.busy} !== 35'd0)
      begin errors++; $display("FAIL reset: acc48=%h v=%b o=%b b=%b acc32=%h, want all 0",
        b48.acc_out, b48.out_valid, b48.ovf, b48.busy, b32.acc_out); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] beats[4] = '{32'd21, 32'd130, -32'sd16256, -32'sd18};
    logic [47:0] e48; logic [31:0] e32;
    e48 = RELU ? 48'd0 : -48'sd16123; e32 = RELU ? 32'd0 : -32'sd16123;
    out_ready = 1'b1; start = 1'b1; acc_len = 16'd4; tick(); start = 1'b0;
    checks++;
    if (b48.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", b48.busy); end
    for (int i = 0; i < 4; i++) begin
      psum_in = beats[i]; psum_valid = 1'b1; tick();
      if (i < 3) begin
        checks++;
        if (b48.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid beat %0d: got 1 want 0", i); end
      end
    end
    psum_valid = 1'b0;
    checks++;
    if ({b48.out_valid, b48.acc_out, b48.ovf} !== {1'b1, e48, 1'b0} ||
        {b32.out_valid, b32.acc_out, b32.ovf} !== {1'b1, e32, 1'b0})
      begin errors++; $display("FAIL basic_result: got %b %h %b / %h %b want 1 %h 0 / %h 0",
        b48.out_valid, b48.acc_out, b48.ovf, b32.acc_out, b32.ovf, e48, e32); end
    tick();
    checks++;
    if ({b48.out_valid, b48.busy} !== 2'b00) begin errors++;
      $display("FAIL basic_one_cycle: valid=%b busy=%b want 0 0", b48.out_valid, b48.busy); end
  endtask

  task automatic test_gaps();
    bit pat[6] = '{1, 0, 0, 1, 0, 1};
    out_ready = 1'b1; start = 1'b1; acc_len = 16'd3; tick(); start = 1'b0;
    psum_in = 32'd7;
    for (int i = 0; i < 6; i++) begin
      psum_valid = pat[i]; tick();
      if (i < 5) begin
        checks++;
        if (b48.out_valid !== 1'b0) begin errors++; $display("FAIL gaps_early step %0d: got 1 want 0", i); end
      end
    end
    psum_valid = 1'b0;
    checks++;
    if ({b48.out_valid, b48.acc_out} !== {1'b1, 48'd21} || b32.acc_out !== 32'd21)
      begin errors++; $display("FAIL gaps_result: got %b %0d/%0d want 1 21", b48.out_valid, b48.acc_out, b32.acc_out); end
    tick();
  endtask

  task automatic test_hold();
    out_ready = 1'b0; start = 1'b1; acc_len = 16'd2; tick(); start = 1'b0;
    psum_valid = 1'b1; psum_in = 32'd100; tick();
    psum_in = -32'sd3; tick();
    psum_in = 32'd1000;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({b48.out_valid, b48.acc_out, b48.busy} !== {1'b1, 48'd97, 1'b1} || b32.acc_out !== 32'd97)
        begin errors++; $display("FAIL hold_stable cyc %0d: got %b %0d want 1 97", i, b48.out_valid, b48.acc_out); end
    end
    psum_valid = 1'b0; out_ready = 1'b1; tick();
    checks++;
    if ({b48.out_valid, b48.busy, b32.busy} !== 3'b000)
      begin errors++; $display("FAIL hold_release: valid=%b busy=%b want 0 0", b48.out_valid, b48.busy); end
    // Beats while idle are ignored; a fresh len=1 result carries only its own beat.
    psum_valid = 1'b1; psum_in = 32'd55; tick();
    start = 1'b1; acc_len = 16'd1; psum_valid = 1'b0; tick(); start = 1'b0;
    psum_valid = 1'b1; psum_in = 32'd4; tick(); psum_valid = 1'b0;
    checks++;
    if ({b48.out_valid, b48.acc_out} !== {1'b1, 48'd4})
      begin errors++; $display("FAIL hold_no_residue: got %b %0d want 1 4", b48.out_valid, b48.acc_out); end
    tick();
  endtask

  task automatic test_overflow();
    out_ready = 1'b1; start = 1'b1; acc_len = 16'd2; tick(); start = 1'b0;
    psum_valid = 1'b1; psum_in = 32'h7FFF_FFFF; tick();
    psum_in = 32'd1; tick(); psum_valid = 1'b0;
    checks++;
    if ({b32.out_valid, b32.acc_out, b32.ovf} !== {1'b1, (RELU ? 32'd0 : 32'h8000_0000), 1'b1})
      begin errors++; $display("FAIL ovf32: got %b %h %b want 1 %h 1", b32.out_valid, b32.acc_out, b32.ovf,
        (RELU ? 32'd0 : 32'h8000_0000)); end
    checks++;
    if ({b48.acc_out, b48.ovf} !== {48'h0000_8000_0000, 1'b0})
      begin errors++; $display("FAIL ovf48: got %h %b want 000080000000 0", b48.acc_out, b48.ovf); end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; start = 1'b1; acc_len = 16'd1; tick(); start = 1'b0;
    psum_valid = 1'b1; psum_in = 32'd9; tick(); psum_valid = 1'b0;
    checks++;
    if ({b48.out_valid, b48.acc_out} !== {1'b1, 48'd9})
      begin errors++; $display("FAIL b2b_first: got %b %0d want 1 9", b48.out_valid, b48.acc_out); end
    out_ready = 1'b1; start = 1'b1; acc_len = 16'd1; tick(); start = 1'b0;
    checks++;
    if ({b48.out_valid, b48.busy} !== 2'b01)
      begin errors++; $display("FAIL b2b_restart: valid=%b busy=%b want 0 1", b48.out_valid, b48.busy); end
    psum_valid = 1'b1; psum_in = 32'd5; tick(); psum_valid = 1'b0;
    checks++;
    if ({b48.out_valid, b48.acc_out, b32.acc_out} !== {1'b1, 48'd5, 32'd5})
      begin errors++; $display("FAIL b2b_second: got %b %0d want 1 5", b48.out_valid, b48.acc_out); end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1; start = 1'b1; acc_len = 16'd4; tick(); start = 1'b0;
    psum_valid = 1'b1; psum_in = 32'd11; tick(); tick();
    psum_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({b48.acc_out, b48.out_valid, b48.ovf, b48.busy} !== 51'd0 || b32.busy !== 1'b0)
      begin errors++; $display("FAIL reset_mid: acc=%h v=%b o=%b b=%b want all 0",
        b48.acc_out, b48.out_valid, b48.ovf, b48.busy); end
    start = 1'b1; acc_len = 16'd0; tick(); start = 1'b0;
    checks++;
    if (b48.busy !== 1'b0) begin errors++; $display("FAIL len0_ignored: busy=%b want 0", b48.busy); end
    start = 1'b1; acc_len = 16'd2; tick(); start = 1'b0;
    psum_valid = 1'b1; psum_in = 32'd3; tick(); psum_in = 32'd4; tick(); psum_valid = 1'b0;
    checks++;
    if ({b48.out_valid, b48.acc_out} !== {1'b1, 48'd7})
      begin errors++; $display("FAIL reset_fresh: got %b %0d want 1 7", b48.out_valid, b48.acc_out); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] beats[$];
    logic [63:0] r48, r32;
    bit o48, o32;
    int len, hold;
    for (int t = 0; t < 40; t++) begin
      beats.delete();
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++)
        case ($urandom_range(0, 3))
          0: beats.push_back(32'h7FFF_FFFF);
          1: beats.push_back(32'h8000_0000);
          default: beats.push_back($urandom);
        endcase
      model(beats, 48, r48, o48);
      model(beats, 32, r32, o32);
      out_ready = 1'b0; start = 1'b1; acc_len = 16'(len); tick(); start = 1'b0;
      for (int i = 0; i < len; i++) begin
        while ($urandom_range(0, 2) == 0) begin
          psum_valid = 1'b0; psum_in = $urandom; tick();
          checks++;
          if (b48.out_valid !== 1'b0) begin errors++; $display("FAIL rand_early t%0d: got 1 want 0", t); end
        end
        psum_valid = 1'b1; psum_in = beats[i]; tick();
      end
      hold = $urandom_range(0, 3);
      for (int h = 0; h <= hold; h++) begin
        checks++;
        if ({b48.out_valid, b48.acc_out, b48.ovf} !== {1'b1, r48[47:0], o48} ||
            {b32.out_valid, b32.acc_out, b32.ovf} !== {1'b1, r32[31:0], o32})
          begin errors++; $display("FAIL rand_result t%0d h%0d: got %b %h %b / %h %b want 1 %h %b / %h %b",
            t, h, b48.out_valid, b48.acc_out, b48.ovf, b32.acc_out, b32.ovf, r48[47:0], o48, r32[31:0], o32); end
        psum_valid = $urandom_range(0, 1); psum_in = $urandom;
        out_ready = (h == hold); tick();
      end
      psum_valid = 1'b0; out_ready = 1'b0;
      checks++;
      if ({b48.out_valid, b48.busy, b32.busy} !== 3'b000)
        begin errors++; $display("FAIL rand_release t%0d: valid=%b busy=%b want 0 0", t, b48.out_valid, b48.busy); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_hold();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
